// File: rtl/serial_pkg.sv
// Shared serial-stream definitions: serializer FSM states and the default word
// width also used by the pattern-detector stream generators.
package serial_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and
// streams them one bit per clock, back-to-back words with no idle bubble.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy,
  output state_t           state_dbg
);

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready depends only on registered state, never on din_valid.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shreg_shift;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic             ser_out_q, ser_out_n;
  logic             ser_valid_q, ser_valid_n;
  logic             first_bit, next_bit;
  logic             last, accept;

  // Output end of the shift register fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit   = din[WIDTH-1];
      assign next_bit    = shreg[WIDTH-2];
      assign shreg_shift = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit   = din[0];
      assign next_bit    = shreg[1];
      assign shreg_shift = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign last      = (bit_cnt == LAST);
  assign din_ready = (state == IDLE) || ((state == SHIFT) && last);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    ser_out_n   = ser_out_q;
    ser_valid_n = ser_valid_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = SHIFT;
          shreg_n     = din;
          bit_cnt_n   = '0;
          ser_out_n   = first_bit;
          ser_valid_n = 1'b1;
        end else begin
          ser_out_n   = IDLE_BIT;
          ser_valid_n = 1'b0;
        end
      end
      SHIFT: begin
        if (!last) begin
          shreg_n   = shreg_shift;
          ser_out_n = next_bit;
          bit_cnt_n = bit_cnt + CW'(1);
        end else if (accept) begin
          // Reload on the last bit so the next word follows with no gap.
          shreg_n     = din;
          bit_cnt_n   = '0;
          ser_out_n   = first_bit;
          ser_valid_n = 1'b1;
        end else begin
          state_n     = IDLE;
          ser_out_n   = IDLE_BIT;
          ser_valid_n = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        ser_out_n   = IDLE_BIT;
        ser_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      ser_out_q   <= ser_out_n;
      ser_valid_q <= ser_valid_n;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign busy       = ser_valid_q;
  assign frame_done = ser_valid_q && last;
  assign state_dbg  = state;

endmodule
